// File: rtl/fd3e_wr_arb_if.sv
// Bus between N write requesters and the fd3e_wr_arb round-robin arbiter.
// The master side is the requester/bank environment, the slave side is the arbiter.
interface fd3e_wr_arb_if #(
  parameter int N = 4
);
  logic [N-1:0]   REQ;
  logic [3*N-1:0] DIN;
  logic           CE;
  logic [2:0]     D;
  logic [N-1:0]   GNT;
  logic           BUSY;

  modport master (
    output REQ, DIN,
    input  CE, D, GNT, BUSY
  );

  modport slave (
    input  REQ, DIN,
    output CE, D, GNT, BUSY
  );
endinterface

// File: rtl/fd3e_wr_arb.sv
// Round-robin write arbiter in front of a 3-bit clock-enabled register bank.
// One requester wins per arbitration, its word is latched at that edge and
// written with a single-cycle CE pulse, then GAP idle cycles follow.
module fd3e_wr_arb #(
  parameter int N   = 4,
  parameter int GAP = 1,
  parameter int PW  = 3
) (
  input  logic          CK,
  input  logic          RST,
  fd3e_wr_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WRITE, COOL} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   win_q, win_d;
  logic            ce_q, ce_d;
  logic [2:0]      d_q, d_d;
  logic [N-1:0]    gnt_q, gnt_d;

  logic            hit;
  logic [PW-1:0]   win_c;
  int              idx;

  // Find the first requester at or after the pointer, wrapping at N
  always_comb begin
    hit   = 1'b0;
    win_c = '0;
    idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (bus.REQ[idx]) begin
        hit   = 1'b1;
        win_c = PW'(idx);
      end
    end
  end

  // Next-state and registered-output logic for IDLE/WRITE/COOL
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    ce_d    = 1'b0;
    gnt_d   = '0;
    d_d     = d_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          win_d   = win_c;
          d_d     = bus.DIN[3*int'(win_c) +: 3];
          gnt_d   = N'(1) << win_c;
          ce_d    = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        ptr_d = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);
        if (GAP == 0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = PW'(GAP - 1);
          state_d = COOL;
        end
      end
      COOL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
      ce_q    <= 1'b0;
      d_q     <= 3'b000;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      ce_q    <= ce_d;
      d_q     <= d_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.CE   = ce_q;
  assign bus.D    = d_q;
  assign bus.GNT  = gnt_q;
  assign bus.BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_fd3e_wr_arb.sv
// Bench for fd3e_wr_arb: three instances (GAP=1, GAP=0, GAP=3) share one
// stimulus stream; a per-instance behavioural model is compared every cycle
// and directed checks pin grant order, gap spacing, reset and data capture.
module tb_fd3e_wr_arb;

  localparam int NR = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] din;

  int checks   = 0;
  int failures = 0;

  fd3e_wr_arb_if #(.N(NR)) if0 ();
  fd3e_wr_arb_if #(.N(NR)) if1 ();
  fd3e_wr_arb_if #(.N(NR)) if2 ();

  assign if0.REQ = req;
  assign if0.DIN = din;
  assign if1.REQ = req;
  assign if1.DIN = din;
  assign if2.REQ = req;
  assign if2.DIN = din;

  fd3e_wr_arb #(.N(NR), .GAP(1), .PW(3)) dut0 (.CK(clk), .RST(rst), .bus(if0.slave));
  fd3e_wr_arb #(.N(NR), .GAP(0), .PW(3)) dut1 (.CK(clk), .RST(rst), .bus(if1.slave));
  fd3e_wr_arb #(.N(NR), .GAP(3), .PW(3)) dut2 (.CK(clk), .RST(rst), .bus(if2.slave));

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state per instance
  int          m_busy [3];
  int          m_ptr  [3];
  logic        m_ce   [3];
  logic [3:0]  m_gnt  [3];
  logic [2:0]  m_d    [3];
  logic        m_bo   [3];
  logic        prev_ce[3];
  logic        model_valid = 1'b0;
  logic [2:0]  bank0;
  int          gap_of [3] = '{1, 0, 3};

  task automatic checkOutput(input string name, input int m,
                             input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut%0d got=%0h expected=%0h at %0t", name, m, got, exp, $time);
    end
  endtask

  // Model: after a write the arbiter stays busy for 1+GAP cycles, otherwise
  // it picks the first requester from the pointer round the ring
  task automatic model_step(input int m);
    int w;
    if (rst) begin
      m_busy[m] = 0; m_ptr[m] = 0; m_ce[m] = 1'b0;
      m_gnt[m] = '0; m_d[m] = '0; m_bo[m] = 1'b0;
    end else if (m_busy[m] > 0) begin
      m_busy[m] = m_busy[m] - 1;
      m_ce[m]   = 1'b0;
      m_gnt[m]  = '0;
      m_bo[m]   = (m_busy[m] > 0);
    end else if (req != 4'b0000) begin
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && req[(m_ptr[m] + k) % NR]) w = (m_ptr[m] + k) % NR;
      m_d[m]    = din[3*w +: 3];
      m_gnt[m]  = 4'(1) << w;
      m_ce[m]   = 1'b1;
      m_busy[m] = 1 + gap_of[m];
      m_bo[m]   = 1'b1;
      m_ptr[m]  = (w + 1) % NR;
    end
  endtask

  // Advance the models on every rising edge
  always @(posedge clk) begin
    if (rst) model_valid = 1'b1;
    for (int m = 0; m < 3; m++) model_step(m);
  end

  // Bank attached to instance 0 captures D when CE is high
  always @(posedge clk) begin
    if (if0.CE) bank0 <= if0.D;
  end

  task automatic compare_one(input int m, input logic ce, input logic [3:0] gnt,
                             input logic [2:0] d, input logic busy);
    checkOutput("ce", m, ce, m_ce[m]);
    checkOutput("gnt", m, gnt, m_gnt[m]);
    checkOutput("d", m, d, m_d[m]);
    checkOutput("busy", m, busy, m_bo[m]);
    checkOutput("gnt_onehot", m, ($countones(gnt) <= 1), 1);
    checkOutput("ce_eq_or_gnt", m, ce, |gnt);
    checkOutput("ce_back_to_back", m, (ce && prev_ce[m]), 0);
    prev_ce[m] = ce;
  endtask

  // Compare every instance against its model on the falling edge
  always @(negedge clk) begin
    if (model_valid) begin
      compare_one(0, if0.CE, if0.GNT, if0.D, if0.BUSY);
      compare_one(1, if1.CE, if1.GNT, if1.D, if1.BUSY);
      compare_one(2, if2.CE, if2.GNT, if2.D, if2.BUSY);
    end
  end

  task automatic applyStimulus(input logic r, input logic [3:0] q,
                               input logic [11:0] dv, input int cycles);
    rst = r;
    req = q;
    din = dv;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Directed sequence
  initial begin
    int n;
    logic [11:0] dv;
    prev_ce = '{1'b0, 1'b0, 1'b0};
    dv = 12'h5A3;

    // Reset held two cycles with all requests high
    applyStimulus(1'b1, 4'b1111, dv, 2);
    checkOutput("rst_ce", 0, if0.CE, 0);
    checkOutput("rst_gnt", 0, if0.GNT, 0);
    checkOutput("rst_d", 0, if0.D, 0);
    checkOutput("rst_busy", 0, if0.BUSY, 0);

    // First grant after release goes to requester 0
    applyStimulus(1'b0, 4'b1111, dv, 1);
    checkOutput("first_gnt", 0, if0.GNT, 4'b0001);
    checkOutput("first_gnt", 1, if1.GNT, 4'b0001);

    // GAP=0 instance cycles grants 1,2,3,0 every two cycles
    for (int j = 1; j <= 4; j++) begin
      applyStimulus(1'b0, 4'b1111, dv, 2);
      checkOutput("rr_gnt", 1, if1.GNT, 32'(4'(1) << (j % 4)));
      checkOutput("rr_ce", 1, if1.CE, 1);
    end

    // Pointer skip and wrap on the GAP=0 instance
    applyStimulus(1'b0, 4'b0000, dv, 1);
    applyStimulus(1'b0, 4'b1000, dv, 1);
    checkOutput("skip_gnt3", 1, if1.GNT, 4'b1000);
    applyStimulus(1'b0, 4'b0011, dv, 2);
    checkOutput("wrap_gnt0", 1, if1.GNT, 4'b0001);
    applyStimulus(1'b0, 4'b0011, dv, 2);
    checkOutput("next_gnt1", 1, if1.GNT, 4'b0010);
    applyStimulus(1'b0, 4'b0000, dv, 6);

    // Single request on the GAP=1 instance
    dv[8:6] = 3'b101;
    applyStimulus(1'b0, 4'b0100, dv, 1);
    checkOutput("single_gnt", 0, if0.GNT, 4'b0100);
    checkOutput("single_ce", 0, if0.CE, 1);
    checkOutput("single_d", 0, if0.D, 3'b101);
    checkOutput("single_busy", 0, if0.BUSY, 1);
    applyStimulus(1'b0, 4'b0000, dv, 1);
    checkOutput("single_ce_off", 0, if0.CE, 0);
    checkOutput("single_busy_cool", 0, if0.BUSY, 1);
    checkOutput("single_bank", 0, bank0, 3'b101);
    applyStimulus(1'b0, 4'b0000, dv, 1);
    checkOutput("single_busy_off", 0, if0.BUSY, 0);
    applyStimulus(1'b0, 4'b0000, dv, 6);

    // Gap enforcement on the GAP=3 instance with REQ held
    n = 0;
    applyStimulus(1'b0, 4'b0001, dv, 1);
    while (!if2.CE && n < 20) begin
      applyStimulus(1'b0, 4'b0001, dv, 1);
      n++;
    end
    checkOutput("gap_first_ce", 2, if2.CE, 1);
    n = 0;
    do begin
      applyStimulus(1'b0, 4'b0001, dv, 1);
      n++;
    end while (!if2.CE && n < 20);
    checkOutput("gap_spacing", 2, n, 5);

    // Reset during COOL, then pointer must be back at 0
    applyStimulus(1'b0, 4'b0001, dv, 1);
    checkOutput("cool_busy", 2, if2.BUSY, 1);
    applyStimulus(1'b1, 4'b1001, dv, 1);
    checkOutput("rst_cool_busy", 2, if2.BUSY, 0);
    checkOutput("rst_cool_ce", 2, if2.CE, 0);
    applyStimulus(1'b0, 4'b1001, dv, 1);
    checkOutput("rst_ptr_gnt", 2, if2.GNT, 4'b0001);
    applyStimulus(1'b0, 4'b0000, dv, 6);

    // Early drop: word latched at arbitration survives REQ/DIN changes
    dv[5:3] = 3'b110;
    applyStimulus(1'b0, 4'b0010, dv, 1);
    checkOutput("drop_d", 0, if0.D, 3'b110);
    dv[5:3] = 3'b011;
    applyStimulus(1'b0, 4'b0000, dv, 1);
    checkOutput("drop_bank", 0, bank0, 3'b110);
    applyStimulus(1'b0, 4'b0000, dv, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
